dcmem_pipe: RTL
===============

// Module: dcmem_pipe
// PURPOSE
//  Parametrised successor to the data memory: DEPTH x DATA_WIDTH synchronous RAM with a
//  valid/ready request port, byte-enabled writes, 1-cycle registered read response,
//  hardware zero-fill after reset/clear and out-of-range detection. Sits between the
//  core's MEM stage and the data store; MEM stage stalls while req_ready=0.
// PARAMETERS
//  ADDR_WIDTH  5   request address width
//  DATA_WIDTH  16  word width; must be a multiple of 8
//  DEPTH       32  implemented words, 1..2**ADDR_WIDTH
//  BE_WIDTH    DATA_WIDTH/8  derived (localparam), byte lanes
// PORTS
//  clk        in   1           clock, all state on posedge
//  rst_n      in   1           async active-low reset
//  clr        in   1           1-cycle pulse: restart zero-fill
//  req_valid  in   1           request present
//  req_ready  out  1           block accepts request (0 during INIT)
//  req_we     in   1           1=write, 0=read
//  req_addr   in   ADDR_WIDTH  word address
//  req_wdata  in   DATA_WIDTH  write data
//  req_be     in   BE_WIDTH    byte enables, bit i -> bits [8i+7:8i]
//  rsp_valid  out  1           read response valid (one cycle, no backpressure)
//  rsp_rdata  out  DATA_WIDTH  read data
//  rsp_err    out  1           response error (out of range / parity)
//  init_done  out  1           1 once zero-fill complete
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0; FSM=INIT, fill ptr=0.
//  FSM INIT: writes 0 to word[ptr], ptr++ each cycle; after word DEPTH-1 -> RUN (DEPTH cycles).
//  FSM RUN: req_ready=1, init_done=1. clr in RUN -> INIT next cycle, ptr=0, init_done=0.
//  clr in INIT restarts ptr at 0. Async rst_n low at any time aborts fill and in-flight rsp.
//  Handshake: request accepted on posedge with req_valid & req_ready; one per cycle.
//  Write: lanes with req_be[i]=1 updated at accept edge; other lanes kept; no response.
//  Write with req_be=0: no state change, no response.
//  Read: accepted at edge N -> rsp_valid=1 with rsp_rdata at edge N+1, for exactly one cycle.
//  Read of address written at previous edge returns new data (write-then-read ordering).
//  req_addr >= DEPTH: write dropped; read returns rsp_rdata=0, rsp_err=1.
//  clr accepted same cycle as a request: request is NOT accepted (req_ready already 0 next?
//   no: clr has priority, req_ready is forced 0 in the cycle clr=1).
//  Read accepted the cycle before clr still produces its response.
//  rsp_rdata/rsp_err hold last value when rsp_valid=0.
// CONFIGURATION
//  DCMEM_PARITY_EN defined: one even-parity bit stored per byte lane, written with data
//   (INIT stores parity 0). Extra input err_inject (1 bit): when 1 on an accepted write,
//   stored parity of enabled lanes inverted. Read checks all lanes; any mismatch -> rsp_err=1,
//   rsp_rdata still returns stored data.
//  DCMEM_PARITY_EN undefined: no parity storage, no err_inject port; rsp_err only for range.
// TESTING
//  Reset, hold req_valid=1 -> req_ready=0 for 32 cycles, init_done=1 at cycle 32; read all -> 0.
//  Write 0xBEEF @3 be=11, then write 0x12xx @3 be=10 -> read @3 returns 0x12EF, 1-cycle latency.
//  Back-to-back write 0xA5A5 @7, read @7 next cycle -> rsp_rdata=0xA5A5, rsp_err=0.
//  DEPTH=20: write @25 then read @25 -> rsp_rdata=0, rsp_err=1; word 5 (25 mod 20) unchanged.
//  Write 0x1111 @2, read @2 with clr next cycle -> response 0x1111 delivered, then 20/32-cycle
//   refill, read @2 -> 0; rst_n pulse mid-fill -> rsp_valid=0, fill restarts at 0.
//  DCMEM_PARITY_EN: write 0x00FF @4 err_inject=1 be=01 -> read @4 rsp_err=1, data 0x00FF.

Source files
------------

// File: rtl/dcmem_pipe_if.sv
// Request/response bus between the MEM stage (master) and dcmem_pipe (slave).
// err_inject is present only when DCMEM_PARITY_EN is defined.
interface dcmem_pipe_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
`ifdef DCMEM_PARITY_EN
  logic                  err_inject;
`endif

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
`ifdef DCMEM_PARITY_EN
    output err_inject,
`endif
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
`ifdef DCMEM_PARITY_EN
    input  err_inject,
`endif
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dcmem_pipe.sv
// DEPTH x DATA_WIDTH data memory: valid/ready requests, byte-enabled writes,
// 1-cycle registered read response, zero-fill after reset/clr, range check.
// Optional per-lane even parity with error injection: define DCMEM_PARITY_EN.
module dcmem_pipe #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  dcmem_pipe_if.slave bus,
  output logic        init_done
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PTR_W-1:0]      r_fill_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_ready;
  logic                  w_fill_we;
  logic                  w_accept;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_in_range;
  logic [PTR_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_par_err;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state; clr in INIT keeps filling from word 0
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (!clr && r_fill_ptr == LAST_PTR) w_state_nxt = S_RUN;
      S_RUN:   if (clr) w_state_nxt = S_INIT;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // FSM: outputs; clr blocks acceptance in the same cycle
  always_comb begin
    w_ready   = 1'b0;
    w_fill_we = 1'b0;
    init_done = 1'b0;
    case (r_state)
      S_INIT: w_fill_we = 1'b1;
      S_RUN: begin
        w_ready   = !clr;
        init_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_fill_ptr <= '0;
    else if (clr || r_state == S_RUN)    r_fill_ptr <= '0;
    else if (r_fill_ptr != LAST_PTR)     r_fill_ptr <= r_fill_ptr + 1'b1;
  end

  assign bus.req_ready = w_ready;
  assign w_accept      = bus.req_valid & w_ready;
  assign w_in_range    = ({1'b0, bus.req_addr} < DEPTH_A);
  assign w_wr          = w_accept & bus.req_we & w_in_range;
  assign w_rd          = w_accept & ~bus.req_we;
  assign w_idx         = w_in_range ? bus.req_addr[PTR_W-1:0] : '0;
  assign w_rd_word     = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_mem[r_fill_ptr] <= '0;
    end else if (w_wr) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (bus.req_be[i]) r_mem[w_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

`ifdef DCMEM_PARITY_EN
  logic [BE_WIDTH-1:0] r_par [DEPTH];
  logic [BE_WIDTH-1:0] w_par_wr;

  always_comb begin
    w_par_wr  = '0;
    w_par_err = 1'b0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      w_par_wr[i] = (^bus.req_wdata[8*i +: 8]) ^ bus.err_inject;
      if ((^w_rd_word[8*i +: 8]) != r_par[w_idx][i]) w_par_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_par[r_fill_ptr] <= '0;
    end else if (w_wr) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (bus.req_be[i]) r_par[w_idx][i] <= w_par_wr[i];
      end
    end
  end
`else
  assign w_par_err = 1'b0;
`endif

  // Data and error hold their last value between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_rd;
      if (w_rd) begin
        r_rsp_rdata <= w_in_range ? w_rd_word : '0;
        r_rsp_err   <= !w_in_range || w_par_err;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule
